// File: rtl/asymfifo_drain_framer.sv
// Drain stage for the 8b-in/16b-out asymmetric FIFO: pops words into a 2-entry skid and frames them.
// Optional build macro DRAIN_STALL_CNT_EN adds a saturating stall_cnt output.
module asymfifo_drain_framer #(
    parameter int unsigned data_width = 16,
    parameter int unsigned len_width  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [len_width-1:0]  frame_len,
    input  logic                  fifo_empty,
    input  logic                  fifo_error,
    input  logic [data_width-1:0] fifo_data_out,
    output logic                  fifo_pop_req_n,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [data_width-1:0] m_data,
    output logic                  m_last,
    output logic                  frame_done,
    output logic                  err_flag,
`ifdef DRAIN_STALL_CNT_EN
    output logic [15:0]           stall_cnt,
`endif
    input  logic                  err_clr
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StStop = 2'd2;
    localparam logic [1:0] StHalt = 2'd3;

    localparam logic [len_width-1:0] LenOne = 1;

    logic [1:0]            state_q, state_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [data_width-1:0] data0_q, data0_d, data1_q, data1_d;
    logic                  last0_q, last0_d, last1_q, last1_d;
    logic [len_width-1:0]  fcnt_q, fcnt_d, flen_q, flen_d;
    logic                  frame_done_q, frame_done_d;
    logic                  err_q, err_d;

    logic                  pop;
    logic                  take;
    logic                  pop_last;
    logic [len_width-1:0]  eff_len;

    assign pop            = ((state_q == StRun) || (state_q == StStop)) && !fifo_empty &&
                            (cnt_q < 2'd2);
    assign fifo_pop_req_n = !pop;
    assign m_valid        = (cnt_q != 2'd0);
    assign take           = m_valid && m_ready;
    assign m_data         = data0_q;
    assign m_last         = last0_q;
    assign frame_done     = frame_done_q;
    assign err_flag       = err_q;

    // A zero frame_len counts as one word per frame; length is latched on a frame's first pop.
    always_comb begin
        eff_len = flen_q;
        if (fcnt_q == '0) begin
            eff_len = (frame_len == '0) ? LenOne : frame_len;
        end
    end

    assign pop_last = (fcnt_q == (eff_len - LenOne));

    always_comb begin
        fcnt_d  = fcnt_q;
        flen_d  = flen_q;
        state_d = state_q;
        err_d   = err_q;
        if (pop) begin
            if (fcnt_q == '0) begin
                flen_d = eff_len;
            end
            fcnt_d = pop_last ? '0 : (fcnt_q + LenOne);
        end
        if (fifo_error) begin
            state_d = StHalt;
            err_d   = 1'b1;
        end else begin
            if (err_clr) begin
                err_d = 1'b0;
            end
            case (state_q)
                StIdle: if (enable) state_d = StRun;
                // Judge frame position after this clock's pop so no frame is left half-popped.
                StRun:  if (!enable) state_d = (fcnt_d == '0) ? StIdle : StStop;
                StStop: if (pop && pop_last) state_d = StIdle;
                StHalt: begin
                    if (err_clr) begin
                        state_d = StIdle;
                        fcnt_d  = '0;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        data0_d = data0_q;
        data1_d = data1_q;
        last0_d = last0_q;
        last1_d = last1_q;
        case (cnt_q)
            2'd0: begin
                if (pop) begin
                    data0_d = fifo_data_out;
                    last0_d = pop_last;
                    cnt_d   = 2'd1;
                end
            end
            2'd1: begin
                if (pop && take) begin
                    data0_d = fifo_data_out;
                    last0_d = pop_last;
                end else if (pop) begin
                    data1_d = fifo_data_out;
                    last1_d = pop_last;
                    cnt_d   = 2'd2;
                end else if (take) begin
                    last0_d = 1'b0;
                    cnt_d   = 2'd0;
                end
            end
            2'd2: begin
                if (take) begin
                    data0_d = data1_q;
                    last0_d = last1_q;
                    cnt_d   = 2'd1;
                end
            end
            default: cnt_d = 2'd0;
        endcase
    end

    assign frame_done_d = take && last0_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= 2'd0;
            data0_q      <= '0;
            data1_q      <= '0;
            last0_q      <= 1'b0;
            last1_q      <= 1'b0;
            fcnt_q       <= '0;
            flen_q       <= '0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            data0_q      <= data0_d;
            data1_q      <= data1_d;
            last0_q      <= last0_d;
            last1_q      <= last1_d;
            fcnt_q       <= fcnt_d;
            flen_q       <= flen_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
        end
    end

`ifdef DRAIN_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (err_clr) begin
            stall_d = '0;
        end else if (m_valid && !m_ready && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_asymfifo_drain_framer.sv
// Randomised self-checking bench for asymfifo_drain_framer against a queue-based reference model.
// The FIFO itself is modelled by a queue; build with DRAIN_STALL_CNT_EN to also check stall_cnt.
module tb_asymfifo_drain_framer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [7:0]  frame_len = 8'd0;
    logic        fifo_empty = 1'b1;
    logic        fifo_error = 1'b0;
    logic [15:0] fifo_data_out = 16'h0;
    logic        fifo_pop_req_n;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [15:0] m_data;
    logic        m_last;
    logic        frame_done;
    logic        err_flag;
    logic        err_clr = 1'b0;
`ifdef DRAIN_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    asymfifo_drain_framer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .frame_len      (frame_len),
        .fifo_empty     (fifo_empty),
        .fifo_error     (fifo_error),
        .fifo_data_out  (fifo_data_out),
        .fifo_pop_req_n (fifo_pop_req_n),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .m_last         (m_last),
        .frame_done     (frame_done),
        .err_flag       (err_flag),
`ifdef DRAIN_STALL_CNT_EN
        .stall_cnt      (stall_cnt),
`endif
        .err_clr        (err_clr)
    );

    int total = 0;
    int bad = 0;

    logic [15:0] fq[$];
    localparam int MIdle = 0, MRun = 1, MStop = 2, MHalt = 3;
    int          ms;
    logic [16:0] sk[$];
    int          pos, flen, mstall;
    bit          merr, mfd;

    int          lasts_seen, fd_seen, hs_seen;
    logic [20:0] obs_v, exp_v;
    logic [15:0] obs_stall, exp_stall;

    task automatic model_reset();
        ms = MIdle;
        sk.delete();
        pos = 0;
        flen = 0;
        merr = 0;
        mfd = 0;
        mstall = 0;
    endtask

    // Applies FIFO head, snapshots observed/expected, advances the model, then clocks once.
    task automatic step();
        bit          p, v, consumed, islast;
        logic [16:0] head;
        fifo_empty    = (fq.size() == 0);
        fifo_data_out = fifo_empty ? 16'h0 : fq[0];
        #1;
        p    = ((ms == MRun) || (ms == MStop)) && (fq.size() != 0) && (sk.size() < 2);
        v    = (sk.size() != 0);
        head = v ? sk[0] : 17'h0;
        exp_v = {p, v, head[16], mfd, merr, head[15:0]};
        obs_v = {!fifo_pop_req_n, m_valid, v ? m_last : 1'b0, frame_done, err_flag,
                 v ? m_data : 16'h0};
        exp_stall = mstall[15:0];
`ifdef DRAIN_STALL_CNT_EN
        obs_stall = stall_cnt;
`else
        obs_stall = mstall[15:0];
`endif
        if (m_valid && m_ready) hs_seen++;
        if (m_valid && m_ready && m_last) lasts_seen++;
        if (frame_done) fd_seen++;

        consumed = v && m_ready;
        mfd = consumed && head[16];
        if (err_clr) mstall = 0;
        else if (v && !m_ready && mstall < 65535) mstall++;
        if (consumed) void'(sk.pop_front());
        islast = 0;
        if (p) begin
            if (pos == 0) flen = (frame_len == 8'd0) ? 1 : int'(frame_len);
            islast = (pos == flen - 1);
            pos = islast ? 0 : pos + 1;
            sk.push_back({islast, fq[0]});
        end
        if (fifo_error) begin
            ms = MHalt;
            merr = 1;
        end else begin
            if (err_clr) merr = 0;
            case (ms)
                MIdle: if (enable) ms = MRun;
                MRun:  if (!enable) ms = (pos == 0) ? MIdle : MStop;
                MStop: if (p && islast) ms = MIdle;
                default: if (err_clr) begin ms = MIdle; pos = 0; end
            endcase
        end
        @(posedge clk);
        if (obs_v[20] && fq.size() != 0) void'(fq.pop_front());
        @(negedge clk);
    endtask

    task automatic hard_reset();
        rst_n = 1'b0;
        enable = 1'b0;
        fifo_error = 1'b0;
        err_clr = 1'b0;
        fq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [20:0] got;
        repeat (2) @(negedge clk);
        got = {fifo_pop_req_n, m_valid, m_last, frame_done, err_flag, m_data};
        total++;
        if (got !== {1'b1, 5'b0, 15'b0}) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=%h", got, {1'b1, 5'b0, 15'b0});
        end
`ifdef DRAIN_STALL_CNT_EN
        total++;
        if (stall_cnt !== 16'h0) begin
            bad++;
            $display("FAIL reset_stall got=%h want=0000", stall_cnt);
        end
`endif
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_stream();
        lasts_seen = 0; fd_seen = 0; hs_seen = 0;
        frame_len = 8'd4; m_ready = 1'b1; enable = 1'b1;
        for (int i = 0; i < 8; i++) fq.push_back(16'h0100 + 16'(i));
        for (int c = 0; c < 14; c++) begin
            step();
            total++;
            if (obs_v !== exp_v) begin
                bad++;
                $display("FAIL stream c%0d got=%h want=%h", c, obs_v, exp_v);
            end
        end
        total++;
        if (lasts_seen !== 2 || fd_seen !== 2 || hs_seen !== 8) begin
            bad++;
            $display("FAIL stream_counts got last=%0d fd=%0d hs=%0d want 2 2 8",
                     lasts_seen, fd_seen, hs_seen);
        end
        enable = 1'b0;
        step();
    endtask

    task automatic test_backpressure();
        hs_seen = 0;
        frame_len = 8'd3; enable = 1'b1;
        for (int i = 0; i < 9; i++) fq.push_back(16'h0200 + 16'(i));
        for (int c = 0; c < 22; c++) begin
            m_ready = !(c >= 3 && c < 8);
            step();
            total++;
            if (obs_v !== exp_v || obs_stall !== exp_stall) begin
                bad++;
                $display("FAIL backpressure c%0d got=%h/%h want=%h/%h", c, obs_v, obs_stall,
                         exp_v, exp_stall);
            end
        end
        total++;
        if (hs_seen !== 9) begin
            bad++;
            $display("FAIL backpressure_words got=%0d want=9", hs_seen);
        end
        enable = 1'b0;
        step();
    endtask

    task automatic test_stop();
        m_ready = 1'b1; frame_len = 8'd4; enable = 1'b1;
        fq.push_back(16'h0301);
        fq.push_back(16'h0302);
        for (int c = 0; c < 16; c++) begin
            if (c == 5) enable = 1'b0;
            if (c == 7) for (int i = 3; i <= 6; i++) fq.push_back(16'h0300 + 16'(i));
            step();
            total++;
            if (obs_v !== exp_v) begin
                bad++;
                $display("FAIL stop c%0d got=%h want=%h", c, obs_v, exp_v);
            end
        end
        total++;
        if (fq.size() !== 2) begin
            bad++;
            $display("FAIL stop_leftover got=%0d want=2", fq.size());
        end
        fq.delete();
    endtask

    task automatic test_error();
        m_ready = 1'b1; frame_len = 8'd5; enable = 1'b1;
        for (int i = 0; i < 8; i++) fq.push_back(16'h0400 + 16'(i));
        for (int c = 0; c < 20; c++) begin
            fifo_error = (c == 3);
            m_ready    = (c != 4);
            err_clr    = (c == 9) || (c == 12);
            fifo_error = fifo_error || (c == 9);
            step();
            total++;
            if (obs_v !== exp_v) begin
                bad++;
                $display("FAIL error c%0d got=%h want=%h", c, obs_v, exp_v);
            end
        end
        hard_reset();
    endtask

    task automatic test_len0_and_async_reset();
        logic [20:0] got;
        lasts_seen = 0;
        m_ready = 1'b1; frame_len = 8'd0; enable = 1'b1;
        for (int i = 0; i < 3; i++) fq.push_back(16'h0500 + 16'(i));
        for (int c = 0; c < 8; c++) begin
            step();
            total++;
            if (obs_v !== exp_v) begin
                bad++;
                $display("FAIL len0 c%0d got=%h want=%h", c, obs_v, exp_v);
            end
        end
        total++;
        if (lasts_seen !== 3) begin
            bad++;
            $display("FAIL len0_lasts got=%0d want=3", lasts_seen);
        end
        frame_len = 8'd4; m_ready = 1'b0;
        for (int i = 0; i < 3; i++) fq.push_back(16'h0600 + 16'(i));
        for (int c = 0; c < 4; c++) step();
        #2 rst_n = 1'b0;
        #1;
        got = {fifo_pop_req_n, m_valid, m_last, frame_done, err_flag, m_data};
        total++;
        if (got !== {1'b1, 5'b0, 15'b0}) begin
            bad++;
            $display("FAIL async_reset got=%h want=%h", got, {1'b1, 5'b0, 15'b0});
        end
        @(negedge clk);
        fq.delete();
        enable = 1'b0;
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int c = 0; c < 500; c++) begin
            m_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) fq.push_back(16'($urandom));
            if ($urandom_range(0, 30) == 0) enable = ~enable;
            if ($urandom_range(0, 10) == 0) frame_len = 8'($urandom_range(0, 5));
            fifo_error = ($urandom_range(0, 70) == 0);
            err_clr    = merr && ($urandom_range(0, 4) == 0);
            step();
            total++;
            if (obs_v !== exp_v || obs_stall !== exp_stall) begin
                bad++;
                $display("FAIL random c%0d got=%h/%h want=%h/%h", c, obs_v, obs_stall,
                         exp_v, exp_stall);
            end
        end
        fifo_error = 1'b0;
        err_clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_stop();
        test_error();
        test_len0_and_async_reset();
        enable = 1'b1;
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
